// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative signed multiply / divide unit feeding the CPU's HI/LO register
// pair. One operation is accepted at a time through a start/busy/done
// handshake. The core runs one bit per cycle on the unsigned operand
// magnitudes: shift-add for MULT, restoring shift-subtract for DIV. The signs
// are applied in a final FIX cycle, and HI/LO are then written with a single
// strobe.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   request a new operation (sampled only in IDLE)
//   op          in   0 = signed MULT, 1 = signed DIV (sampled with start)
//   a           in   multiplicand / dividend (sampled with start)
//   b           in   multiplier / divisor (sampled with start)
//   busy        out  high whenever the sequencer is not IDLE
//   done        out  one-cycle completion pulse (also for divide-by-zero)
//   div0        out  one-cycle pulse with done when DIV had b == 0
//   hilo_write  out  one-cycle pulse with done when hi/lo were updated
//   hi          out  upper product or remainder
//   lo          out  lower product or quotient
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_ZERO
    } state_t;

    state_t           state_q;
    logic             op_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic [CW-1:0]    cnt_q;
    // acc_hi_q:acc_lo_q is the MULT product accumulator (multiplier shifts
    // out of acc_lo_q) or, for DIV, remainder:dividend-then-quotient.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // opnd_q is the multiplicand magnitude for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0] opnd_q;
    logic             done_q;
    logic             div0_q;
    logic             hilo_write_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct
    // unsigned magnitude.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // One iteration of either algorithm.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;
    logic [WIDTH:0] div_diff;
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd_q};

    // NOTE: every always_comb output is assigned on every path (here each
    // branch is complete); a missing assignment would infer a latch.
    always_comb begin
        if (!op_q) begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            // Trial subtraction fits: keep the difference, quotient bit 1.
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            // Restore: keep the shifted remainder, quotient bit 0.
            acc_hi_d = div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the finished magnitudes.
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    assign prod_mag = {acc_hi_q, acc_lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_mag + 1'b1) : prod_mag;
    assign quot_fix = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
    assign rem_fix  = neg_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
    assign fix_hi   = op_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = op_q ? quot_fix : prod_fix[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // The datapath registers are plain flops, so clearing them on
            // reset costs nothing and keeps outputs deterministic.
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            cnt_q        <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            opnd_q       <= '0;
            done_q       <= 1'b0;
            div0_q       <= 1'b0;
            hilo_write_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            done_q       <= 1'b0;
            div0_q       <= 1'b0;
            hilo_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        neg_a_q  <= a[WIDTH-1];
                        neg_b_q  <= b[WIDTH-1];
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        acc_lo_q <= op ? abs_a : abs_b;
                        opnd_q   <= op ? abs_b : abs_a;
                        state_q  <= (op && (b == '0)) ? S_ZERO : S_RUN;
                    end
                end
                S_RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q         <= fix_hi;
                    lo_q         <= fix_lo;
                    done_q       <= 1'b1;
                    hilo_write_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_ZERO: begin
                    done_q  <= 1'b1;
                    div0_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign div0       = div0_q;
    assign hilo_write = hilo_write_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative signed multiply/divide unit that computes results for the CPU's HI/LO register pair. It accepts one operation at a time from the microcode controller through a start/busy/done handshake. It runs a one-bit-per-cycle shift-add multiply or restoring divide, then writes HI/LO with a single strobe. Divide-by-zero is reported on `div0` so the controller can branch to its exception sequence.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 2.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. `reset` = 0 clears all state immediately.
- `start`  in  1  request a new operation. Sampled only in IDLE.
- `op`  in  1  0 = signed multiply (MULT), 1 = signed divide (DIV). Sampled with `start`.
- `a`  in  WIDTH  rs operand: multiplicand or dividend. Sampled with `start`.
- `b`  in  WIDTH  rt operand: multiplier or divisor. Sampled with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when the operation completes, including the divide-by-zero case.
- `div0`  out  1  one-cycle pulse coincident with `done` when DIV had `b` == 0.
- `hilo_write`  out  1  one-cycle pulse coincident with `done` when HI/LO were updated.
- `hi`  out  WIDTH  registered HI: upper product, or remainder.
- `lo`  out  WIDTH  registered LO: lower product, or quotient.

## Operation
- States: IDLE, RUN, FIX, ZERO.
- IDLE with `start` = 1:
  - Capture `op` and the sign of each operand.
  - Load the magnitudes |a| and |b|.
  - Clear the iteration counter.
  - Go to RUN. If `op` = 1 and `b` == 0, go to ZERO instead.
- `start` is ignored in every other state. Operands are not re-sampled.
- RUN: one iteration per cycle on the unsigned magnitudes.
  - MULT: shift-add over a 2·WIDTH accumulator.
  - DIV: restoring shift-subtract producing quotient and remainder.
  - After WIDTH iterations (counter = WIDTH−1 at the edge), go to FIX.
- FIX: apply signs and write results, then return to IDLE.
  - MULT: 2·WIDTH product is negated if the operand signs differ. hi = upper half, lo = lower half.
  - DIV: quotient is negated if the signs differ (truncation toward zero). Remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - Assert `done` = 1 and `hilo_write` = 1 for the following cycle.
- ZERO: return to IDLE.
  - Assert `done` = 1 and `div0` = 1 for the following cycle.
  - `hilo_write` = 0. `hi`/`lo` keep their previous values.
- Overflow case DIV (−2^(WIDTH−1)) / (−1): lo = 2^(WIDTH−1) bit pattern (0x80000000 for WIDTH 32), hi = 0. No flag.
- All arithmetic is modulo 2^WIDTH per half. The magnitude of −2^(WIDTH−1) is held as an unsigned WIDTH-bit value without loss.
- `done`, `div0` and `hilo_write` are registered outputs, low in every cycle except the completion cycle.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `div0` = 0, `hilo_write` = 0, `hi` = 0, `lo` = 0, counter = 0.
- Let E0 be the edge that accepts `start`.
  - Normal op: E1…E_WIDTH perform the iterations, FIX is occupied after E_WIDTH, and edge E_(WIDTH+1) registers `hi`/`lo`/`done`.
  - So `done` is high in the cycle after E33 (WIDTH = 32): 33 cycles of latency.
  - `busy` is high from after E0 until E_(WIDTH+1). It is low in the same cycle that `done` is high.
- Divide-by-zero: `busy` is high for exactly one cycle; `done`/`div0` are high in the cycle after E1.
- Back-to-back: `start` held high during the `done` cycle is accepted on the next edge. There are no idle bubbles beyond that.
- Reset during RUN/FIX/ZERO aborts the operation:
  - No `done` is issued.
  - HI/LO are cleared to 0.
  - A new `start` is accepted on the first edge after reset is released.
- `a`, `b` and `op` may change freely after E0 without affecting the result.

## Test plan
- MULT a = 7, b = 0xFFFFFFFD (−3): `done` is high exactly 33 cycles after the start edge, with hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, `hilo_write` = 1, `div0` = 0.
- MULT a = 0x80000000, b = 0x80000000 → hi = 0x40000000, lo = 0x00000000. Then MULT 0xFFFFFFFF × 0xFFFFFFFF → hi = 0, lo = 1.
- DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Preload hi/lo via MULT 3 × 5, then DIV 5 / 0: `done` = `div0` = 1 one cycle after E1, `hilo_write` = 0, and hi/lo are unchanged (hi = 0, lo = 15).
- Pulse `start` with different operands at cycles 5 and 20 of a running MULT: both are ignored and the result matches the original operands. Hold `start` high during `done`: the next op is accepted on the following edge.
- Assert `reset` = 0 at iteration 10 of a DIV: `busy`, `done`, `hi`, `lo` all go to 0 immediately with no `done` pulse. After release, MULT 2 × 3 → lo = 6 at the normal latency.
